// File: rtl/inst_rom_arbiter_pkg.sv
// Shared definitions for the instruction ROM arbiter.
//   resp_sel_t     : which port owns the response due next cycle
//   STARVE_MAX_DEF : default count of denied debug cycles before debug is forced
//   CHIP_ENABLE / CHIP_DISABLE / ZERO_WORD : common ROM interface constants
package inst_rom_arbiter_pkg;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'b00,
    RESP_FETCH = 2'b01,
    RESP_DBG   = 2'b10
  } resp_sel_t;

  localparam int          STARVE_MAX_DEF = 4;
  localparam logic        CHIP_ENABLE    = 1'b1;
  localparam logic        CHIP_DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

endpackage

// File: rtl/inst_rom_arbiter_starve_counter.sv
// arb_starve_counter: saturating count of consecutive cycles the debug
// requester was denied.
//   clk, rst : clock, async active-high reset
//   inc      : debug requested but not granted this cycle
//   clr      : debug granted or not requesting (takes priority over inc)
//   at_max   : count has reached MAX (debug must be granted)
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [3:0] cnt;

  assign at_max = (cnt == 4'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares one combinational instruction ROM between the
// pipeline fetch port (priority) and a debug read port. The starvation
// counter forces a debug grant after STARVE_MAX consecutive denied cycles.
// Responses come back exactly one cycle after the grant.
//
// Ports:
//   clk, rst                        : clock, async active-high reset
//   fetch_req/addr/flush, fetch_gnt : fetch request side
//   fetch_rvalid/rdata              : registered fetch response
//   dbg_req/addr, dbg_gnt           : debug request side
//   dbg_rvalid/rdata                : registered debug response
//   rom_ce, rom_addr, rom_inst      : ROM interface (word-aligned address)
//   perf_*_cnt                      : only when INST_ARB_PERF_EN is defined
//
// Build option: INST_ARB_PERF_EN adds saturating grant/stall counters.
//
// resp_sel register:
//   state      | meaning
//   RESP_NONE  | no response due this cycle
//   RESP_FETCH | fetch_rdata holds a valid, unflushed response
//   RESP_DBG   | dbg_rdata holds a valid response
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  input  logic              fetch_flush,
  output logic              fetch_rvalid,
  output logic [INST_W-1:0] fetch_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [INST_W-1:0] dbg_rdata,
`ifdef INST_ARB_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_dbg_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst
);

  logic        dbg_force;
  logic        starve_inc;
  logic        starve_clr;
  resp_sel_t   resp_sel;
  logic [ADDR_W-1:0] sel_addr;

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (dbg_force)
  );

  // dbg_force is only meaningful while debug is still requesting.
  always_comb begin
    fetch_gnt = fetch_req && !(dbg_req && dbg_force);
    dbg_gnt   = dbg_req && !fetch_gnt;
  end

  assign starve_inc = dbg_req && !dbg_gnt;
  assign starve_clr = !dbg_req || dbg_gnt;

  always_comb begin
    sel_addr = '0;
    if (fetch_gnt) begin
      sel_addr = fetch_addr;
    end else if (dbg_gnt) begin
      sel_addr = dbg_addr;
    end
  end

  assign rom_ce   = (fetch_gnt || dbg_gnt) ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr = {sel_addr[ADDR_W-1:2], 2'b00};

  // A flushed fetch still captures data but records no pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_sel    <= RESP_NONE;
      fetch_rdata <= INST_W'(ZERO_WORD);
      dbg_rdata   <= INST_W'(ZERO_WORD);
    end else begin
      if (fetch_gnt) begin
        resp_sel    <= fetch_flush ? RESP_NONE : RESP_FETCH;
        fetch_rdata <= rom_inst;
      end else if (dbg_gnt) begin
        resp_sel    <= RESP_DBG;
        dbg_rdata   <= rom_inst;
      end else begin
        resp_sel    <= RESP_NONE;
      end
    end
  end

  assign fetch_rvalid = (resp_sel == RESP_FETCH);
  assign dbg_rvalid   = (resp_sel == RESP_DBG);

`ifdef INST_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_dbg_cnt   <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (fetch_gnt && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (dbg_gnt && (perf_dbg_cnt != 32'hFFFF_FFFF)) begin
        perf_dbg_cnt <= perf_dbg_cnt + 32'd1;
      end
      if (fetch_req && !fetch_gnt && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
